// File: rtl/muldiv_ctrl_pkg.sv
// Shared opcodes, FSM states and small arithmetic helpers for the multiply/divide sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MdOpMult  = 3'd0,
    MdOpMultu = 3'd1,
    MdOpDiv   = 3'd2,
    MdOpDivu  = 3'd3,
    MdOpMthi  = 3'd4,
    MdOpMtlo  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2
  } md_state_e;

  localparam int unsigned MdDivIters = 32;
  localparam int unsigned CntW       = 6;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is correct as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath: one quotient bit per enabled cycle on unsigned magnitudes.
module muldiv_ctrl_div_iter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  // acc[63:32] is the partial remainder, acc[31:0] the dividend shifting into the quotient.
  logic [63:0] acc_q, acc_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [32:0] trial;

  always_comb begin
    acc_d  = acc_q;
    dvsr_d = dvsr_q;
    trial  = acc_q[63:31] - {1'b0, dvsr_q};
    if (load_i) begin
      acc_d  = {32'd0, dividend_i};
      dvsr_d = divisor_i;
    end else if (en_i) begin
      if (!trial[32]) begin
        acc_d = {trial[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {acc_q[62:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      dvsr_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign quot_o = acc_q[31:0];
  assign rem_o  = acc_q[63:32];

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and multiply/divide sequencer: accepts requests, runs the operation, commits HI/LO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        done
);

  localparam logic [CntW-1:0] MulLast = CntW'(MUL_STAGES);
  localparam logic [CntW-1:0] DivLast = CntW'(MdDivIters + 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            done_q, done_d;

  md_op_e      op;
  logic        accept;
  logic        div_load;
  logic        div_en;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        quot_neg;
  logic        rem_neg;

  assign op     = md_op_e'(req_op);
  assign accept = req_valid && (state_q == StIdle) && !cancel;

  // Low 64 bits of the product of sign/zero-extended operands give the exact 64-bit result;
  // the MUL state's extra cycles leave room to retime this multiplier.
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign quot_neg = sgn_q & (a_q[31] ^ b_q[31]);
  assign rem_neg  = sgn_q & a_q[31];

  muldiv_ctrl_div_iter u_div_iter (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (div_load),
    .en_i       (div_en),
    .dividend_i (mag32(req_a, op == MdOpDiv)),
    .divisor_i  (mag32(req_b, op == MdOpDiv)),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          case (op)
            MdOpMult, MdOpMultu: begin
              state_d = StMul;
              cnt_d   = CntW'(1);
              a_d     = req_a;
              b_d     = req_b;
              sgn_d   = (op == MdOpMult);
            end
            MdOpDiv, MdOpDivu: begin
              state_d  = StDiv;
              cnt_d    = CntW'(1);
              a_d      = req_a;
              b_d      = req_b;
              sgn_d    = (op == MdOpDiv);
              div_load = 1'b1;
            end
            MdOpMthi: hi_d = req_a;
            MdOpMtlo: lo_d = req_a;
            default: ;
          endcase
        end
      end

      StMul: begin
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == MulLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDiv: begin
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DivLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          hi_d    = neg_if(div_rem, rem_neg);
          lo_d    = neg_if(div_quot, quot_neg);
          done_d  = 1'b1;
        end else begin
          div_en = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign done      = done_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with hand-computed HI/LO results and handshake timing.
module tb_muldiv_ctrl;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        done;

  int total;
  int bad;
  int cyc;

  muldiv_ctrl #(.MUL_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .cancel    (cancel),
    .busy      (busy),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accept edge, scramble operands, then wait for req_ready.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h1234_5678;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Checks result, latency and the single done pulse of a MULT/DIV.
  task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo);
    run_op(op, a, b, cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_hi"}, 64'(hi_o), 64'(ehi));
    check({tag, "_lo"}, 64'(lo_o), 64'(elo));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    tick();
    check({tag, "_done_off"}, 64'(done), 64'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    cancel    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);

    // MULT -2*3 with intermediate busy observation
    req_valid = 1'b1;
    req_op    = OpMult;
    req_a     = 32'hFFFF_FFFE;
    req_b     = 32'd3;
    tick();
    req_valid = 1'b0;
    check("mult_busy1", 64'(busy), 64'd1);
    tick();
    check("mult_busy2", 64'(busy), 64'd1);
    check("mult_done_early", 64'(done), 64'd0);
    tick();
    check("mult_busy_end", 64'(busy), 64'd0);
    check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);
    check("mult_done", 64'(done), 64'd1);
    tick();
    check("mult_done_off", 64'(done), 64'd0);

    op_check("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h1);
    op_check("divu_100_7", OpDivu, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    op_check("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_check("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    op_check("divu_by0", OpDivu, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
    op_check("div_m5_by0", OpDiv, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'd1);

    // MTHI/MTLO preload, single cycle, no busy
    req_valid = 1'b1;
    req_op    = OpMthi;
    req_a     = 32'h1111_1111;
    tick();
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi_o), 64'h1111_1111);
    req_op = OpMtlo;
    tick();
    req_valid = 1'b0;
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_lo", 64'(lo_o), 64'h1111_1111);
    check("mtlo_done", 64'(done), 64'd0);

    // DIVU cancelled at cycle 10
    req_valid = 1'b1;
    req_op    = OpDivu;
    req_a     = 32'd1000;
    req_b     = 32'd3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("cxl_busy_pre", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cxl_ready", 64'(req_ready), 64'd1);
    check("cxl_hilo", {hi_o, lo_o}, {32'h1111_1111, 32'h1111_1111});
    check("cxl_done", 64'(done), 64'd0);
    tick();
    check("cxl_done2", 64'(done), 64'd0);

    // MTLO held through a DIVU; taken on the first idle cycle after the commit
    req_valid = 1'b1;
    req_op    = OpDivu;
    req_a     = 32'd100;
    req_b     = 32'd7;
    tick();
    req_op = OpMtlo;
    req_a  = 32'h0000_ABCD;
    cyc    = 0;
    while (!req_ready && cyc < 100) begin
      tick();
      cyc++;
    end
    check("hold_lat", 64'(cyc), 64'd33);
    check("hold_commit", {hi_o, lo_o}, {32'd2, 32'd14});
    check("hold_done", 64'(done), 64'd1);
    tick();
    req_valid = 1'b0;
    check("hold_mtlo", {hi_o, lo_o}, {32'd2, 32'h0000_ABCD});
    check("hold_mtlo_done", 64'(done), 64'd0);

    // cancel wins over req_valid in IDLE
    req_valid = 1'b1;
    cancel    = 1'b1;
    req_op    = OpMthi;
    req_a     = 32'h5555_5555;
    tick();
    check("idlecxl_hi", 64'(hi_o), 64'd2);
    req_op = OpDivu;
    req_a  = 32'd9;
    req_b  = 32'd3;
    tick();
    req_valid = 1'b0;
    cancel    = 1'b0;
    check("idlecxl_busy", 64'(busy), 64'd0);
    check("idlecxl_ready", 64'(req_ready), 64'd1);

    // Reset at divide iteration 16
    req_valid = 1'b1;
    req_op    = OpDivu;
    req_a     = 32'd100;
    req_b     = 32'd7;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("rmid_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_hilo", {hi_o, lo_o}, 64'd0);
    check("rmid_busy", 64'(busy), 64'd0);
    check("rmid_done", 64'(done), 64'd0);
    check("rmid_ready", 64'(req_ready), 64'd1);

    op_check("mult_after_rst", OpMult, 32'd7, 32'd6, 2, 32'd0, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
